// File: rtl/issue_queue_n_if.sv
// Bundle between rename/dispatch, writeback wakeup and the ALU issue ports
// of issue_queue_n. Per-slot/per-port fields are packed [lanes][width], which
// puts slot i at bits [i*W +: W].
interface issue_queue_n_if #(
  parameter int DEPTH      = 16,
  parameter int DISPATCH_W = 2,
  parameter int NUM_FU     = 3,
  parameter int PREG_W     = 6,
  parameter int NUM_WB     = 3
);
  localparam int OCC_W = $clog2(DEPTH + 1);

  // dispatch
  logic [DISPATCH_W-1:0]             disp_valid;
  logic [DISPATCH_W-1:0][PREG_W-1:0] disp_p_rs1, disp_p_rs2, disp_p_rd;
  logic [DISPATCH_W-1:0]             disp_rs1_rdy, disp_rs2_rdy;
  logic [DISPATCH_W-1:0][6:0]        disp_opcode;
  logic [DISPATCH_W-1:0][2:0]        disp_funct3;
  logic [DISPATCH_W-1:0][6:0]        disp_funct7;
  logic [DISPATCH_W-1:0][31:0]       disp_imm;
  logic                              disp_ready;
  // wakeup
  logic [NUM_WB-1:0]                 wb_valid;
  logic [NUM_WB-1:0][PREG_W-1:0]     wb_preg;
  // issue
  logic [NUM_FU-1:0]                 fu_ready, issue_valid;
  logic [NUM_FU-1:0][PREG_W-1:0]     issue_p_rs1, issue_p_rs2, issue_p_rd;
  logic [NUM_FU-1:0][6:0]            issue_opcode;
  logic [NUM_FU-1:0][2:0]            issue_funct3;
  logic [NUM_FU-1:0][6:0]            issue_funct7;
  logic [NUM_FU-1:0][31:0]           issue_imm;
  logic [OCC_W-1:0]                  occupancy;

  modport master (
    output disp_valid, disp_p_rs1, disp_p_rs2, disp_p_rd, disp_rs1_rdy, disp_rs2_rdy,
           disp_opcode, disp_funct3, disp_funct7, disp_imm, wb_valid, wb_preg, fu_ready,
    input  disp_ready, issue_valid, issue_p_rs1, issue_p_rs2, issue_p_rd,
           issue_opcode, issue_funct3, issue_funct7, issue_imm, occupancy
  );

  modport slave (
    input  disp_valid, disp_p_rs1, disp_p_rs2, disp_p_rd, disp_rs1_rdy, disp_rs2_rdy,
           disp_opcode, disp_funct3, disp_funct7, disp_imm, wb_valid, wb_preg, fu_ready,
    output disp_ready, issue_valid, issue_p_rs1, issue_p_rs2, issue_p_rd,
           issue_opcode, issue_funct3, issue_funct7, issue_imm, occupancy
  );
endinterface

// File: rtl/issue_queue_n.sv
// issue_queue_n: collapsing issue queue between rename and NUM_FU ALUs.
// Entries stay contiguous from index 0 (0 = oldest); each cycle the oldest
// ready entries go to ready FU ports in ascending order, survivors shift
// down and new dispatches are appended behind them.
// Optional macro IQ_FLUSH_EN adds a 'flush' input that empties the queue
// and blanks issue while high.
module issue_queue_n #(
  parameter int DEPTH      = 16,
  parameter int DISPATCH_W = 2,
  parameter int NUM_FU     = 3,
  parameter int PREG_W     = 6,
  parameter int NUM_WB     = 3
) (
  input logic           clk,
  input logic           reset,
`ifdef IQ_FLUSH_EN
  input logic           flush,
`endif
  issue_queue_n_if.slave bus
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [PREG_W-1:0] rs1, rs2, rd;
    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [31:0]       imm;
  } uop_t;

  typedef struct packed {
    uop_t op;
    logic rs1_rdy, rs2_rdy;
  } ent_t;

  logic [DEPTH-1:0] vld_q, vld_d;
  ent_t             ent_q [DEPTH];
  ent_t             ent_d [DEPTH];
  logic [DEPTH-1:0] taken;
  logic [OCC_W-1:0] occ;
  logic             disp_ok;
  logic             flush_w;

`ifdef IQ_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  // any writeback bus carrying this tag this cycle
  function automatic logic hit(input logic [PREG_W-1:0] tag,
                               input logic [NUM_WB-1:0] v,
                               input logic [NUM_WB-1:0][PREG_W-1:0] p);
    hit = 1'b0;
    for (int j = 0; j < NUM_WB; j++)
      if (v[j] && p[j] == tag) hit = 1'b1;
  endfunction

  // Space check uses registered occupancy only; same-cycle issues never free slots.
  assign occ            = OCC_W'($countones(vld_q));
  assign disp_ok        = (int'(DEPTH) - int'(occ)) >= int'(DISPATCH_W);
  assign bus.occupancy  = occ;
  assign bus.disp_ready = disp_ok;

  // Select: each ready FU port in ascending order takes the oldest unclaimed eligible entry.
  always_comb begin
    logic found;
    taken            = '0;
    bus.issue_valid  = '0;
    bus.issue_p_rs1  = '0;
    bus.issue_p_rs2  = '0;
    bus.issue_p_rd   = '0;
    bus.issue_opcode = '0;
    bus.issue_funct3 = '0;
    bus.issue_funct7 = '0;
    bus.issue_imm    = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      found = 1'b0;
      if (bus.fu_ready[k] && !flush_w) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (!found && !taken[i] && vld_q[i] && ent_q[i].rs1_rdy && ent_q[i].rs2_rdy) begin
            found               = 1'b1;
            taken[i]            = 1'b1;
            bus.issue_valid[k]  = 1'b1;
            bus.issue_p_rs1[k]  = ent_q[i].op.rs1;
            bus.issue_p_rs2[k]  = ent_q[i].op.rs2;
            bus.issue_p_rd[k]   = ent_q[i].op.rd;
            bus.issue_opcode[k] = ent_q[i].op.opcode;
            bus.issue_funct3[k] = ent_q[i].op.funct3;
            bus.issue_funct7[k] = ent_q[i].op.funct7;
            bus.issue_imm[k]    = ent_q[i].op.imm;
          end
        end
      end
    end
  end

  // Next state: compact survivors (with wakeup applied), then append dispatch slots in order.
  always_comb begin
    int   pos;
    ent_t e;
    vld_d = '0;
    ent_d = ent_q;
    e     = '0;
    pos   = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && !taken[i]) begin
        e = ent_q[i];
        e.rs1_rdy = e.rs1_rdy | hit(e.op.rs1, bus.wb_valid, bus.wb_preg);
        e.rs2_rdy = e.rs2_rdy | hit(e.op.rs2, bus.wb_valid, bus.wb_preg);
        ent_d[pos[IDX_W-1:0]] = e;
        vld_d[pos[IDX_W-1:0]] = 1'b1;
        pos = pos + 1;
      end
    end
    for (int d = 0; d < DISPATCH_W; d++) begin
      if (bus.disp_valid[d] && disp_ok && pos < DEPTH) begin
        e.op.rs1    = bus.disp_p_rs1[d];
        e.op.rs2    = bus.disp_p_rs2[d];
        e.op.rd     = bus.disp_p_rd[d];
        e.op.opcode = bus.disp_opcode[d];
        e.op.funct3 = bus.disp_funct3[d];
        e.op.funct7 = bus.disp_funct7[d];
        e.op.imm    = bus.disp_imm[d];
        // tag 0 is hardwired ready; same-cycle writeback also counts
        e.rs1_rdy = bus.disp_rs1_rdy[d] | (bus.disp_p_rs1[d] == '0) |
                    hit(bus.disp_p_rs1[d], bus.wb_valid, bus.wb_preg);
        e.rs2_rdy = bus.disp_rs2_rdy[d] | (bus.disp_p_rs2[d] == '0) |
                    hit(bus.disp_p_rs2[d], bus.wb_valid, bus.wb_preg);
        ent_d[pos[IDX_W-1:0]] = e;
        vld_d[pos[IDX_W-1:0]] = 1'b1;
        pos = pos + 1;
      end
    end
  end

  // Valid bits: reset (then flush) empties the queue, otherwise take the compacted map.
  always_ff @(posedge clk) begin
    if (reset || flush_w) vld_q <= '0;
    else                  vld_q <= vld_d;
  end

  // Payload carries no reset; it is only observed through valid bits.
  always_ff @(posedge clk) begin
    ent_q <= ent_d;
  end
endmodule

// File: tb/tb_issue_queue_n.sv
// Bench for issue_queue_n: directed scenarios plus randomized traffic. A
// queue-based reference model predicts each cycle's status and issued ops
// into scoreboard queues; a negedge monitor pops and compares.
module tb_issue_queue_n;
  localparam int DEPTH = 16, DW = 2, NFU = 3, PW = 6, NWB = 3;

  logic clk = 1'b0;
  logic reset;
`ifdef IQ_FLUSH_EN
  logic flush;
`endif

  issue_queue_n_if #(.DEPTH(DEPTH), .DISPATCH_W(DW), .NUM_FU(NFU), .PREG_W(PW), .NUM_WB(NWB)) bus ();

  issue_queue_n #(.DEPTH(DEPTH), .DISPATCH_W(DW), .NUM_FU(NFU), .PREG_W(PW), .NUM_WB(NWB)) dut (
    .clk(clk),
    .reset(reset),
`ifdef IQ_FLUSH_EN
    .flush(flush),
`endif
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [PW-1:0] rs1, rs2, rd;
    logic [6:0] opc; logic [2:0] f3; logic [6:0] f7; logic [31:0] imm;
  } op_t;
  typedef struct { op_t op; bit r1; bit r2; } ment_t;
  typedef struct { int port; op_t op; } iexp_t;
  typedef struct { bit drdy; int occ; logic [NFU-1:0] mask; } sexp_t;

  ment_t mq[$];
  iexp_t iq[$];
  sexp_t sq[$];
  int    n_chk = 0, n_pass = 0;
  bit    mon_on = 0;

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
  endtask

  function automatic bit wb_hit(logic [PW-1:0] t);
    for (int j = 0; j < NWB; j++)
      if (bus.wb_valid[j] && bus.wb_preg[j] == t) return 1'b1;
    return 1'b0;
  endfunction

  function automatic op_t port_op(int k);
    op_t o;
    o.rs1 = bus.issue_p_rs1[k]; o.rs2 = bus.issue_p_rs2[k]; o.rd = bus.issue_p_rd[k];
    o.opc = bus.issue_opcode[k]; o.f3 = bus.issue_funct3[k];
    o.f7 = bus.issue_funct7[k]; o.imm = bus.issue_imm[k];
    return o;
  endfunction

  // Reference model: predict this cycle's outputs, advance state, wait for the edge.
  task automatic step();
    sexp_t s;
    ment_t nq[$];
    ment_t m;
    bit    taken[DEPTH];
    bit    fl = 1'b0;
    int    next_fu = 0;
`ifdef IQ_FLUSH_EN
    fl = flush;
`endif
    s.occ  = mq.size();
    s.drdy = (DEPTH - mq.size()) >= DW;
    s.mask = '0;
    foreach (taken[i]) taken[i] = 0;
    // oldest ready entries go to ready ports in ascending port order
    for (int i = 0; i < mq.size(); i++) begin
      if (mq[i].r1 && mq[i].r2) begin
        while (next_fu < NFU && !(bus.fu_ready[next_fu] && !fl)) next_fu++;
        if (next_fu < NFU) begin
          s.mask[next_fu] = 1'b1;
          iq.push_back('{port: next_fu, op: mq[i].op});
          taken[i] = 1;
          next_fu++;
        end
      end
    end
    sq.push_back(s);
    if (reset || fl) mq.delete();
    else begin
      for (int i = 0; i < mq.size(); i++)
        if (!taken[i]) begin
          m = mq[i];
          m.r1 = m.r1 | wb_hit(m.op.rs1);
          m.r2 = m.r2 | wb_hit(m.op.rs2);
          nq.push_back(m);
        end
      if (s.drdy)
        for (int d = 0; d < DW; d++)
          if (bus.disp_valid[d]) begin
            m.op.rs1 = bus.disp_p_rs1[d]; m.op.rs2 = bus.disp_p_rs2[d]; m.op.rd = bus.disp_p_rd[d];
            m.op.opc = bus.disp_opcode[d]; m.op.f3 = bus.disp_funct3[d];
            m.op.f7 = bus.disp_funct7[d]; m.op.imm = bus.disp_imm[d];
            m.r1 = bus.disp_rs1_rdy[d] || m.op.rs1 == 0 || wb_hit(m.op.rs1);
            m.r2 = bus.disp_rs2_rdy[d] || m.op.rs2 == 0 || wb_hit(m.op.rs2);
            nq.push_back(m);
          end
      mq = nq;
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare status every cycle, pop an expected op per presented issue.
  always @(negedge clk) begin
    sexp_t s;
    iexp_t e;
    if (mon_on) begin
      chk("status_expected", sq.size() > 0, 1'b1);
      if (sq.size() > 0) begin
        s = sq.pop_front();
        chk("disp_ready", bus.disp_ready, s.drdy);
        chk("occupancy", bus.occupancy, s.occ);
        chk("issue_valid", bus.issue_valid, s.mask);
      end
      for (int k = 0; k < NFU; k++) begin
        if (bus.issue_valid[k]) begin
          chk("issue_expected", iq.size() > 0, 1'b1);
          if (iq.size() > 0) begin
            e = iq.pop_front();
            chk("issue_port", k, e.port);
            chk("issue_op", port_op(k), e.op);
          end
        end else begin
          chk("idle_port_zero", port_op(k), '0);
        end
      end
    end
  end

  task automatic idle(logic [NFU-1:0] fu);
    bus.disp_valid = '0; bus.disp_rs1_rdy = '0; bus.disp_rs2_rdy = '0;
    bus.wb_valid = '0; bus.fu_ready = fu;
  endtask

  task automatic put(int d, int rs1, int rs2, int rd, bit r1, bit r2);
    bus.disp_valid[d] = 1'b1;
    bus.disp_p_rs1[d] = PW'(rs1); bus.disp_p_rs2[d] = PW'(rs2); bus.disp_p_rd[d] = PW'(rd);
    bus.disp_rs1_rdy[d] = r1; bus.disp_rs2_rdy[d] = r2;
    bus.disp_opcode[d] = 7'($urandom); bus.disp_funct3[d] = 3'($urandom);
    bus.disp_funct7[d] = 7'($urandom); bus.disp_imm[d] = $urandom;
  endtask

  task automatic wb(int j, int tag);
    bus.wb_valid[j] = 1'b1;
    bus.wb_preg[j]  = PW'(tag);
  endtask

  task automatic rand_inputs(int tmax, int prdy, int pwb, int pfu);
    bus.disp_valid = '0;
    for (int d = 0; d < DW; d++)
      if ($urandom_range(0, 99) < 60)
        put(d, $urandom_range(0, tmax), $urandom_range(0, tmax), $urandom_range(0, 63),
            $urandom_range(0, 99) < prdy, $urandom_range(0, 99) < prdy);
    for (int j = 0; j < NWB; j++) begin
      bus.wb_valid[j] = $urandom_range(0, 99) < pwb;
      bus.wb_preg[j]  = PW'($urandom_range(0, tmax));
    end
    for (int k = 0; k < NFU; k++) bus.fu_ready[k] = $urandom_range(0, 99) < pfu;
  endtask

  initial begin
    reset = 1'b1;
`ifdef IQ_FLUSH_EN
    flush = 1'b0;
`endif
    bus.disp_p_rs1 = '0; bus.disp_p_rs2 = '0; bus.disp_p_rd = '0;
    bus.disp_opcode = '0; bus.disp_funct3 = '0; bus.disp_funct7 = '0; bus.disp_imm = '0;
    bus.wb_preg = '0;
    idle(3'b000);
    @(posedge clk);
    #1;
    mon_on = 1;
    // reset held two cycles: empty, ready, nothing issued
    step(); step();
    reset = 1'b0;

    // two ready ops issue together the next cycle
    idle(3'b111); put(0, 1, 2, 10, 1, 1); put(1, 3, 4, 11, 1, 1); step();
    idle(3'b111); step(); step();

    // wakeup: eligible only the cycle after the wakeup edge
    idle(3'b111); put(0, 20, 5, 12, 0, 1); step();
    idle(3'b111); step();
    idle(3'b111); wb(0, 20); step();
    idle(3'b111); step(); step();

    // fill to 15 unready entries (rs2 = tag 0 is implicitly ready)
    for (int c = 0; c < 7; c++) begin
      idle(3'b111); put(0, 40 + 2 * c, 0, 2 * c, 0, 0); put(1, 41 + 2 * c, 0, 2 * c + 1, 0, 0); step();
    end
    idle(3'b111); put(0, 54, 0, 14, 0, 0); step();
    repeat (2) begin idle(3'b111); put(0, 60, 61, 15, 1, 1); put(1, 62, 63, 16, 1, 1); step(); end
    idle(3'b111); wb(0, 40); wb(1, 41); wb(2, 42); step();
    idle(3'b111); step(); step();
    // reset mid-operation clears the queue
    reset = 1'b1; idle(3'b000); step();
    reset = 1'b0; step();

    // age order with a gap in fu_ready
    idle(3'b000); put(0, 7, 7, 1, 1, 1); put(1, 7, 7, 2, 1, 1); step();
    idle(3'b000); put(0, 7, 7, 3, 1, 1); put(1, 7, 7, 4, 1, 1); step();
    idle(3'b101); step();
    idle(3'b111); step(); step();

    // invalid slot 0 with valid slot 1 leaves no gap
    idle(3'b000); put(1, 0, 0, 33, 0, 0); step();
    idle(3'b001); step(); step();

`ifdef IQ_FLUSH_EN
    // flush with a dispatch: queue empties, no issue while flush is high
    idle(3'b000); put(0, 9, 9, 1, 0, 0); put(1, 9, 9, 2, 0, 0); step();
    idle(3'b000); put(0, 9, 9, 3, 1, 1); put(1, 9, 9, 4, 1, 1); step();
    idle(3'b000); put(0, 9, 9, 5, 1, 1); step();
    idle(3'b111); put(0, 9, 9, 6, 1, 1); flush = 1'b1; step();
    flush = 1'b0; idle(3'b111); step(); step();
`endif

    // randomized phases: free flow, congestion with narrow tag space, resets/flushes
    for (int ph = 0; ph < 4; ph++) begin
      for (int c = 0; c < 500; c++) begin
        case (ph)
          0: rand_inputs(63, 80, 30, 70);
          1: rand_inputs(15, 10, 40, 25);
          2: rand_inputs(7, 30, 60, 90);
          default: rand_inputs(31, 50, 50, 50);
        endcase
        reset = (ph >= 2) && ($urandom_range(0, 99) < 2);
`ifdef IQ_FLUSH_EN
        flush = (ph == 3) && ($urandom_range(0, 99) < 3);
`endif
        step();
      end
    end
    reset = 1'b0;
`ifdef IQ_FLUSH_EN
    flush = 1'b0;
`endif
    idle(3'b111); step(); step();
    mon_on = 0;
    chk("issue_queue_drained", iq.size(), 0);
    chk("status_queue_drained", sq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
